// File: rtl/sgd_x_wb_arbiter.sv
// sgd_x_wb_arbiter
//   Drains the per-engine x FIFOs into one DMA write of the model buffer.
//   A pass issues a single write command covering every chunk, then pops
//   BEATS_PER_BANK beats from engine 0, then engine 1, ... engine
//   ENGINE_NUM-1, and repeats that sweep once per chunk.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse that begins a pass (honoured in IDLE only)
//   addr_model        host byte address of the model buffer
//   dimension         feature count of x
//   fifo_rd_data      first-word-fall-through head word of each engine FIFO
//   fifo_empty        per-FIFO empty flag
//   fifo_rd_en        per-FIFO pop (one-hot or zero)
//   cmd_start         one-cycle DMA write command strobe
//   cmd_addr          DMA write address, valid with cmd_start
//   cmd_length        DMA write length in bytes, valid with cmd_start
//   data_out          write data beat
//   data_valid        data_out qualifier
//   data_almost_full  DMA data path back-pressure
//   busy              high outside IDLE
//   done              one-cycle end-of-pass pulse
//   err_zero_dim      sticky: a pass was started with dimension == 0
//   stall_cycles      saturating count of DRAIN cycles without a pop
module sgd_x_wb_arbiter #(
  parameter int ENGINE_NUM     = 8,
  parameter int BEATS_PER_BANK = 4,
  parameter int CHUNK_FEATURES = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [63:0]                 addr_model,
  input  logic [31:0]                 dimension,
  input  logic [ENGINE_NUM-1:0][511:0] fifo_rd_data,
  input  logic [ENGINE_NUM-1:0]       fifo_empty,
  output logic [ENGINE_NUM-1:0]       fifo_rd_en,
  output logic                        cmd_start,
  output logic [63:0]                 cmd_addr,
  output logic [31:0]                 cmd_length,
  output logic [511:0]                data_out,
  output logic                        data_valid,
  input  logic                        data_almost_full,
  output logic                        busy,
  output logic                        done,
  output logic                        err_zero_dim,
  output logic [31:0]                 stall_cycles
);

  localparam int EW = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam int BW = (BEATS_PER_BANK > 1) ? $clog2(BEATS_PER_BANK) : 1;
  localparam logic [EW-1:0] ENG_LAST  = EW'(ENGINE_NUM - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_BANK - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    CMD   = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t state, state_nxt;

  logic [63:0]   addr_lat;
  logic [31:0]   len_lat;
  logic [31:0]   total_beats;
  logic [31:0]   beat_cnt;
  logic [EW-1:0] eng;
  logic [BW-1:0] beat;
  logic [31:0]   chunks_calc;
  logic [31:0]   beats_calc;
  logic          pop_p0;
  logic          last_pop_p0;

  // ceil(dim / CHUNK_FEATURES); the sum is widened so dimension near 2^32
  // cannot wrap before the divide.
  function automatic logic [31:0] ceil_chunks(input logic [31:0] dim);
    logic [32:0] sum;
    sum = {1'b0, dim} + 33'(CHUNK_FEATURES - 1);
    return 32'(sum / 33'(CHUNK_FEATURES));
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign chunks_calc = ceil_chunks(dimension);
  assign beats_calc  = chunks_calc * 32'(ENGINE_NUM * BEATS_PER_BANK);

  // Stage p0: pop decision. Strict engine order: only the FIFO under the
  // pointer may be popped, so an empty engine stalls the whole pass.
  assign pop_p0      = (state == DRAIN) && !fifo_empty[eng] && !data_almost_full;
  assign last_pop_p0 = pop_p0 && (beat_cnt == total_beats - 32'd1);

  always_comb begin
    fifo_rd_en = '0;
    if (pop_p0) fifo_rd_en[eng] = 1'b1;
  end

  assign cmd_start  = (state == CMD);
  assign cmd_addr   = addr_lat;
  assign cmd_length = len_lat;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (dimension == 32'd0) ? DONE : CMD;
      CMD:     state_nxt = DRAIN;
      DRAIN:   if (last_pop_p0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr_lat     <= '0;
      len_lat      <= '0;
      total_beats  <= '0;
      beat_cnt     <= '0;
      eng          <= '0;
      beat         <= '0;
      err_zero_dim <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        if (dimension == 32'd0) begin
          err_zero_dim <= 1'b1;
        end else begin
          addr_lat    <= addr_model;
          total_beats <= beats_calc;
          len_lat     <= {beats_calc[25:0], 6'b0};
          beat_cnt    <= '0;
          eng         <= '0;
          beat        <= '0;
        end
      end
      if (pop_p0) begin
        beat_cnt <= beat_cnt + 32'd1;
        if (beat == BEAT_LAST) begin
          beat <= '0;
          eng  <= (eng == ENG_LAST) ? '0 : eng + EW'(1);
        end else begin
          beat <= beat + BW'(1);
        end
      end else if (state == DRAIN) begin
        stall_cycles <= sat_inc32(stall_cycles);
      end
    end
  end

  // Stage p1: registered write beat, one cycle behind the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      data_valid <= pop_p0;
      if (pop_p0) data_out <= fifo_rd_data[eng];
    end
  end

endmodule

// File: tb/tb_sgd_x_wb_arbiter.sv
module tb_sgd_x_wb_arbiter;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [63:0]          addr_model;
  logic [31:0]          dimension;
  logic [7:0][511:0]    fifo_rd_data;
  logic [7:0]           fifo_empty;
  logic [7:0]           fifo_rd_en;
  logic                 cmd_start;
  logic [63:0]          cmd_addr;
  logic [31:0]          cmd_length;
  logic [511:0]         data_out;
  logic                 data_valid;
  logic                 data_almost_full;
  logic                 busy;
  logic                 done;
  logic                 err_zero_dim;
  logic [31:0]          stall_cycles;

  int nchecks = 0;
  int nfails  = 0;
  int exp_stall_total = 0;
  logic exp_err = 1'b0;
  int fcnt [8];

  sgd_x_wb_arbiter #(.ENGINE_NUM(8), .BEATS_PER_BANK(4), .CHUNK_FEATURES(512)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_model(addr_model),
    .dimension(dimension), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .cmd_start(cmd_start), .cmd_addr(cmd_addr),
    .cmd_length(cmd_length), .data_out(data_out), .data_valid(data_valid),
    .data_almost_full(data_almost_full), .busy(busy), .done(done),
    .err_zero_dim(err_zero_dim), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Word i of engine e's FIFO: unique per engine and position.
  function automatic logic [511:0] mk(input int e, input int i);
    return {{15{32'hC0DE_0000 | 32'(e)}}, 32'(i)};
  endfunction

  always_comb begin
    for (int e = 0; e < 8; e++) fifo_rd_data[e] = mk(e, fcnt[e]);
  end

  always @(posedge clk) begin
    for (int e = 0; e < 8; e++) if (fifo_rd_en[e]) fcnt[e] <= fcnt[e] + 1;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_rd_en"},  fifo_rd_en, 0);
    chk({tag, "_cmd"},    cmd_start, 0);
    chk({tag, "_addr"},   cmd_addr, 0);
    chk({tag, "_len"},    cmd_length, 0);
    chk({tag, "_dvld"},   data_valid, 0);
    chk({tag, "_dout"},   data_out, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_stall"},  stall_cycles, 0);
    chk({tag, "_err"},    err_zero_dim, 0);
  endtask

  // One write-back pass. af_at/em_at/rst_at are pop counts at which the
  // disturbance begins (-1 = none). ign: assert start while done is high.
  task automatic run_pass(input string tag, input logic [31:0] dim, input logic [63:0] addr,
                          input int exp_beats, input logic [31:0] exp_len,
                          input int af_at, input int af_len,
                          input int em_at, input int em_eng, input int em_len,
                          input int rst_at, input bit ign);
    int ecnt [8];
    int ncmd = 0, nbeats = 0, pops = 0, ndone = 0, multi = 0, viol = 0;
    int first_v = -1, last_v = -1, done_it = -1, af_left = 0, em_left = 0;
    int exp_stalls = 0, bad = 0, k, e;
    bit af_used = 0, em_used = 0;
    logic [63:0] gaddr = '0;
    logic [31:0] glen = '0;
    for (int j = 0; j < 8; j++) ecnt[j] = fcnt[j];
    if (af_at >= 0) exp_stalls += af_len;
    if (em_at >= 0) exp_stalls += em_len;

    @(posedge clk); #1;
    dimension = dim; addr_model = addr; start = 1'b1;
    for (int it = 0; it < 400; it++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (ign && done) begin start = 1'b1; dimension = 32'd512; end
      if (rst_at >= 0 && pops == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk_zero({tag, "_rst"});
        @(posedge clk); #1;
        rst = 1'b0;
        exp_stall_total = 0;
        exp_err = 1'b0;
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (fifo_rd_en != 0 || done || busy || data_valid) bad++;
        end
        chk({tag, "_quiet_after_rst"}, bad, 0);
        return;
      end
      if (af_at >= 0 && !af_used && pops == af_at) begin af_left = af_len; af_used = 1; end
      if (em_at >= 0 && !em_used && pops == em_at) begin em_left = em_len; em_used = 1; end
      data_almost_full = (af_left > 0);
      fifo_empty = '0;
      if (em_left > 0) fifo_empty[em_eng] = 1'b1;

      @(negedge clk);
      if (cmd_start) begin ncmd++; gaddr = cmd_addr; glen = cmd_length; end
      if ($countones(fifo_rd_en) > 1) multi++;
      if ((af_left > 0 || em_left > 0) && fifo_rd_en != 0) viol++;
      pops += $countones(fifo_rd_en);
      if (data_valid) begin
        k = nbeats;
        e = (k / 4) % 8;
        chk($sformatf("%s_beat%0d", tag, k), data_out, mk(e, ecnt[e]));
        ecnt[e]++;
        if (first_v < 0) first_v = it;
        last_v = it;
        nbeats++;
      end
      if (done) begin ndone++; if (done_it < 0) done_it = it; end
      if (af_left > 0) af_left--;
      if (em_left > 0) em_left--;
      if (done_it >= 0 && it >= done_it + 3) break;
    end
    data_almost_full = 1'b0;
    fifo_empty = '0;

    exp_stall_total += exp_stalls;
    if (dim == 32'd0) exp_err = 1'b1;
    chk({tag, "_ncmd"}, ncmd, (dim != 32'd0) ? 1 : 0);
    if (dim != 32'd0) begin
      chk({tag, "_cmd_addr"}, gaddr, addr);
      chk({tag, "_cmd_len"},  glen, exp_len);
      chk({tag, "_span"}, last_v - first_v, exp_beats - 1 + exp_stalls);
    end
    chk({tag, "_nbeats"}, nbeats, exp_beats);
    chk({tag, "_pops"},   pops, exp_beats);
    chk({tag, "_ndone"},  ndone, 1);
    chk({tag, "_done_at"}, done_it, (dim == 32'd0) ? 0 : 1 + exp_beats + exp_stalls);
    chk({tag, "_onehot"}, multi, 0);
    chk({tag, "_held"},   viol, 0);
    chk({tag, "_stall"},  stall_cycles, exp_stall_total);
    chk({tag, "_err"},    err_zero_dim, exp_err);
    chk({tag, "_idle"},   busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr_model = '0; dimension = '0;
    fifo_empty = '0; data_almost_full = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    //        tag     dim   addr       beats len    af      em           rst  ign
    run_pass("d512",  512,  64'h1000,  32, 2048,  -1, 0,  -1, 0, 0,     -1,  0);
    run_pass("d513",  513,  64'h2000,  64, 4096,  -1, 0,  -1, 0, 0,     -1,  1);
    run_pass("d0",    0,    64'h3000,  0,  0,     -1, 0,  -1, 0, 0,     -1,  1);
    run_pass("afull", 512,  64'h4000,  32, 2048,  10, 10, -1, 0, 0,     -1,  0);
    run_pass("e3mt",  512,  64'h5000,  32, 2048,  -1, 0,  12, 3, 5,     -1,  0);
    run_pass("rstm",  512,  64'h6000,  32, 2048,  -1, 0,  -1, 0, 0,     11,  0);
    run_pass("post",  512,  64'h1000,  32, 2048,  -1, 0,  -1, 0, 0,     -1,  0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfails);
    $finish;
  end

endmodule
